alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Decode/issue controller on the producing side of the ALU's 3-bit op_code interface (SLL=000, SRL=001, ADD=010, SUB=011, LSW=100, CLR=101, EMK=110, INC=111).
- Accepts 9-bit instructions over a valid/ready handshake, reads two register-file operands, issues op_code plus operands to the ALU, waits for the result and writes it back.
- Sits between the fetch stage and the ALU/register file; one instruction in flight at a time.

Parameters:
- DW, 8, datapath width of operands/results
- AW, 3, register-file address width
- TIMEOUT, 16, max cycles in WAIT before abort (range 1..255)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- instr  in  9  [8:6] opcode, [5:3] rd (also src A), [2:0] rs (src B)
- rf_raddr_a  out  AW  read address A (= rd)
- rf_raddr_b  out  AW  read address B (= rs)
- rf_rdata_a  in  DW  combinational read data A
- rf_rdata_b  in  DW  combinational read data B
- alu_op  out  3  op_code to ALU
- alu_a  out  DW  operand A
- alu_b  out  DW  operand B
- alu_valid  out  1  ALU request valid
- alu_ready  in  1  ALU accepts request
- alu_result  in  DW  ALU result
- alu_done  in  1  alu_result valid (single-cycle pulse)
- rf_we  out  1  write-back enable
- rf_waddr  out  AW  write-back address
- rf_wdata  out  DW  write-back data
- err  out  1  sticky timeout flag
- retired  out  16  count of written-back instructions

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high, sampled on rising edge.
- Reset values:
  - state=IDLE, instr_ready=1.
  - alu_valid=0, rf_we=0, err=0, retired=0.
  - alu_op=000, alu_a=0, alu_b=0, rf_waddr=0, rf_wdata=0.
  - Internal instruction register=0.
- Reset mid-operation: aborts any state next cycle; no write-back, no alu_valid, counters cleared.
- State machine:
  - IDLE: instr_ready=1. On instr_valid&instr_ready, latch instr → READ.
  - READ: rf_raddr_a/b driven from latched rd/rs. At the clock edge, capture rf_rdata_a/b into alu_a/alu_b and drive alu_op=opcode.
    - Opcode CLR → WB with wdata=0 (ALU bypassed).
    - Otherwise → ISSUE.
  - ISSUE: alu_valid=1. alu_op/a/b are held stable until alu_ready is sampled high.
    - On alu_valid&alu_ready → WAIT, and alu_valid drops the next cycle.
    - There is no timeout in ISSUE.
  - WAIT: alu_valid=0; timeout counter increments each cycle.
    - On alu_done: capture alu_result → WB.
    - If the counter reaches TIMEOUT without alu_done: set err=1 → IDLE, no write-back.
    - alu_done sampled outside WAIT is ignored.
  - WB: rf_we=1 for exactly one cycle, rf_waddr=rd, rf_wdata=captured value; retired+=1 (wraps 0xFFFF→0) → IDLE.
- instr_ready is 1 only in IDLE; instructions offered in other states are not consumed.
- Latency: accept at cycle 0 (IDLE).
  - Earliest ISSUE at cycle 2.
  - With alu_ready=1 in cycle 2 and alu_done in cycle 3: WB at cycle 4, next accept at cycle 5.
  - CLR path: WB at cycle 2, next accept at cycle 3.
- Timeout counter: 8-bit, cleared on entry to WAIT. Abort fires when the count equals TIMEOUT, i.e. TIMEOUT cycles spent in WAIT without alu_done.
  - alu_done arriving in the same cycle the count reaches TIMEOUT wins: write-back proceeds, err unchanged.
- err is cleared only by reset.
- All opcodes other than CLR take the identical ALU path; the controller does not interpret operand semantics (shift amounts, LSW, EMK, INC are ALU concerns). INC still reads and forwards B.
- Only registered outputs; no combinational path from alu_done/alu_ready to any output.

Test Plan:
- ADD back-to-back: reset, RF r1=0x05 r2=0x03; instr=9'b010_001_010, ALU replies alu_ready=1 immediately and alu_done next cycle with 0x08 → alu_op=010, alu_a=0x05, alu_b=0x03; rf_we pulse one cycle with waddr=1, wdata=0x08 at cycle 4; retired=1; instr_ready high at cycle 5.
- CLR bypass: instr=9'b101_110_000 → alu_valid never asserted; rf_we=1, waddr=6, wdata=0x00 at cycle 2; retired increments.
- ALU backpressure: SUB with alu_ready held low 4 cycles → alu_valid stays 1 and alu_op/a/b stay stable for all 4 cycles; the handshake completes on the 5th cycle; instr_ready stays 0 throughout.
- Timeout: TIMEOUT=16, SLL issued, alu_done never asserted → after 16 WAIT cycles err=1, state IDLE, no rf_we, retired unchanged; a following ADD completes normally with err still 1.
- Timeout boundary: alu_done asserted exactly on the 16th WAIT cycle → write-back occurs and err stays 0.
- Reset mid-WAIT: assert reset during WAIT, then pulse alu_done → no rf_we; retired=0, err=0, instr_ready=1 one cycle after reset deasserts.

Source files
------------

// File: rtl/alu_issue_if.sv
// ============================================================================
// Module  : alu_issue_if
// Brief   : Fetch, register-file and ALU signals around the issue controller
// Revision: 1.0
// ============================================================================
`default_nettype none

interface alu_issue_if #(
    parameter int DW = 8,
    parameter int AW = 3
);
    logic          instr_valid;
    logic          instr_ready;
    logic [8:0]    instr;
    logic [AW-1:0] rf_raddr_a;
    logic [AW-1:0] rf_raddr_b;
    logic [DW-1:0] rf_rdata_a;
    logic [DW-1:0] rf_rdata_b;
    logic [2:0]    alu_op;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic          alu_valid;
    logic          alu_ready;
    logic [DW-1:0] alu_result;
    logic          alu_done;
    logic          rf_we;
    logic [AW-1:0] rf_waddr;
    logic [DW-1:0] rf_wdata;
    logic          err;
    logic [15:0]   retired;

    // master is the issue controller; slave is its surroundings
    modport master (
        input  instr_valid, instr, rf_rdata_a, rf_rdata_b,
               alu_ready, alu_result, alu_done,
        output instr_ready, rf_raddr_a, rf_raddr_b, alu_op, alu_a, alu_b,
               alu_valid, rf_we, rf_waddr, rf_wdata, err, retired
    );

    modport slave (
        output instr_valid, instr, rf_rdata_a, rf_rdata_b,
               alu_ready, alu_result, alu_done,
        input  instr_ready, rf_raddr_a, rf_raddr_b, alu_op, alu_a, alu_b,
               alu_valid, rf_we, rf_waddr, rf_wdata, err, retired
    );
endinterface

`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
// ============================================================================
// Module  : alu_issue_ctrl
// Brief   : Single-issue decode/issue controller: RF read, ALU issue, write-back
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_issue_ctrl #(
    parameter int DW      = 8,
    parameter int AW      = 3,
    parameter int TIMEOUT = 16
) (
    input wire          clk,
    input wire          reset,
    alu_issue_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_WB    = 3'd4
    } state_t;

    localparam logic [2:0] c_op_clr   = 3'b101;
    // Abort happens at the end of the TIMEOUT-th WAIT cycle without alu_done
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    state_t        r_state;
    logic [8:0]    r_instr;
    logic [7:0]    r_tmo_cnt;
    logic          r_instr_ready;
    logic [2:0]    r_alu_op;
    logic [DW-1:0] r_alu_a;
    logic [DW-1:0] r_alu_b;
    logic          r_alu_valid;
    logic          r_rf_we;
    logic [AW-1:0] r_rf_waddr;
    logic [DW-1:0] r_rf_wdata;
    logic          r_err;
    logic [15:0]   r_retired;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_instr       <= '0;
            r_tmo_cnt     <= '0;
            r_instr_ready <= 1'b1;
            r_alu_op      <= '0;
            r_alu_a       <= '0;
            r_alu_b       <= '0;
            r_alu_valid   <= 1'b0;
            r_rf_we       <= 1'b0;
            r_rf_waddr    <= '0;
            r_rf_wdata    <= '0;
            r_err         <= 1'b0;
            r_retired     <= '0;
        end else begin
            r_rf_we <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.instr_valid && r_instr_ready) begin
                        r_instr       <= bus.instr;
                        r_instr_ready <= 1'b0;
                        r_state       <= S_READ;
                    end
                end
                S_READ: begin
                    r_alu_a  <= bus.rf_rdata_a;
                    r_alu_b  <= bus.rf_rdata_b;
                    r_alu_op <= r_instr[8:6];
                    if (r_instr[8:6] == c_op_clr) begin
                        r_rf_we    <= 1'b1;
                        r_rf_waddr <= AW'(r_instr[5:3]);
                        r_rf_wdata <= '0;
                        r_state    <= S_WB;
                    end else begin
                        r_alu_valid <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_alu_valid && bus.alu_ready) begin
                        r_alu_valid <= 1'b0;
                        r_tmo_cnt   <= '0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // A result in the final allowed cycle still beats the abort
                    if (bus.alu_done) begin
                        r_rf_we    <= 1'b1;
                        r_rf_waddr <= AW'(r_instr[5:3]);
                        r_rf_wdata <= bus.alu_result;
                        r_state    <= S_WB;
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        r_err         <= 1'b1;
                        r_instr_ready <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 8'd1;
                    end
                end
                S_WB: begin
                    r_retired     <= r_retired + 16'd1;
                    r_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_alu_valid   <= 1'b0;
                    r_instr_ready <= 1'b1;
                    r_state       <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.instr_ready = r_instr_ready;
    assign bus.rf_raddr_a  = AW'(r_instr[5:3]);
    assign bus.rf_raddr_b  = AW'(r_instr[2:0]);
    assign bus.alu_op      = r_alu_op;
    assign bus.alu_a       = r_alu_a;
    assign bus.alu_b       = r_alu_b;
    assign bus.alu_valid   = r_alu_valid;
    assign bus.rf_we       = r_rf_we;
    assign bus.rf_waddr    = r_rf_waddr;
    assign bus.rf_wdata    = r_rf_wdata;
    assign bus.err         = r_err;
    assign bus.retired     = r_retired;
endmodule

`default_nettype wire
